// File: rtl/gpu_axi_pkg.sv
// Shared AXI burst encodings, response codes, FSM states and
// the burst next-address helper for the host-to-memory bridge.
package gpu_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_VALID
    } rd_state_t;

    function automatic logic burst_err(
        input logic [1:0] burst,
        input logic [7:0] len
    );
        logic wrap_ok;
        wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                  (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

    // WRAP lengths are 2^n-1, so len doubles as the in-block mask.
    function automatic logic [31:0] next_addr(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [1:0]  burst
    );
        logic [31:0] mask;
        logic [31:0] inc;
        logic [31:0] res;
        mask = {24'd0, len};
        inc  = addr + 32'd1;
        case (burst)
            BURST_INCR: res = inc;
            BURST_WRAP: res = (addr & ~mask) | (inc & mask);
            default:    res = addr;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-channel burst tracker: latches the burst on the address
// handshake, then steps word address and beat count per beat.
module axi_burst_addr_gen
    import gpu_axi_pkg::*;
#(
    parameter int MW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [MW-1:0] load_addr,
    input  logic [7:0]    load_len,
    input  logic [1:0]    load_burst,
    input  logic          advance,
    output logic [MW-1:0] addr,
    output logic          last,
    output logic          err
);

    logic [7:0]    count;
    logic [7:0]    len;
    logic [1:0]    burst;
    logic [MW-1:0] nxt_addr;

    assign nxt_addr = MW'(next_addr(32'(addr), len, burst));
    assign last     = (count == len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr  <= '0;
            count <= '0;
            len   <= '0;
            burst <= BURST_FIXED;
            err   <= 1'b0;
        end else if (load) begin
            addr  <= load_addr;
            count <= '0;
            len   <= load_len;
            burst <= load_burst;
            err   <= burst_err(load_burst, load_len);
        end else if (advance) begin
            addr  <= nxt_addr;
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/axi_burst_mem_bridge.sv
// AXI4 burst slave bridging host bursts onto a word-wide memory
// with separate write and read ports, one FSM per direction.
module axi_burst_mem_bridge
    import gpu_axi_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    localparam int OFF = $clog2(DATA_WIDTH / 8),
    localparam int MW  = ADDR_WIDTH - OFF
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_awaddr,
    input  logic [7:0]              S_AXI_awlen,
    input  logic [1:0]              S_AXI_awburst,
    input  logic                    S_AXI_awvalid,
    output logic                    S_AXI_awready,
    input  logic [DATA_WIDTH-1:0]   S_AXI_wdata,
    input  logic [DATA_WIDTH/8-1:0] S_AXI_wstrb,
    input  logic                    S_AXI_wlast,
    input  logic                    S_AXI_wvalid,
    output logic                    S_AXI_wready,
    output logic [1:0]              S_AXI_bresp,
    output logic                    S_AXI_bvalid,
    input  logic                    S_AXI_bready,
    input  logic [ADDR_WIDTH-1:0]   S_AXI_araddr,
    input  logic [7:0]              S_AXI_arlen,
    input  logic [1:0]              S_AXI_arburst,
    input  logic                    S_AXI_arvalid,
    output logic                    S_AXI_arready,
    output logic [DATA_WIDTH-1:0]   S_AXI_rdata,
    output logic [1:0]              S_AXI_rresp,
    output logic                    S_AXI_rlast,
    output logic                    S_AXI_rvalid,
    input  logic                    S_AXI_rready,
    output logic                    mem_we,
    output logic [MW-1:0]           mem_waddr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_re,
    output logic [MW-1:0]           mem_raddr,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic LAT_LAST = (READ_LATENCY == 2);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic          aw_hs, w_hs, ar_hs, r_adv, capture;
    logic          w_last, w_gen_err, wlast_err, w_err;
    logic          r_last, r_err;
    logic          lat_cnt;
    logic [MW-1:0] w_addr, r_addr;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic          unused_lsb;

    assign unused_lsb = ^{S_AXI_awaddr[OFF-1:0], S_AXI_araddr[OFF-1:0]};

    // Write channel
    assign S_AXI_awready = (w_state == W_IDLE) && s_axi_aresetn;
    assign S_AXI_wready  = (w_state == W_DATA);
    assign S_AXI_bvalid  = (w_state == W_RESP);
    assign aw_hs = S_AXI_awvalid && S_AXI_awready;
    assign w_hs  = S_AXI_wvalid && S_AXI_wready;
    assign w_err = w_gen_err || wlast_err;
    assign S_AXI_bresp = (S_AXI_bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

    assign mem_we    = w_hs && !w_gen_err;
    assign mem_waddr = w_addr;
    assign mem_wdata = S_AXI_wdata;
    assign mem_wstrb = S_AXI_wstrb;

    axi_burst_addr_gen #(.MW(MW)) u_wgen (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .load       (aw_hs),
        .load_addr  (S_AXI_awaddr[ADDR_WIDTH-1:OFF]),
        .load_len   (S_AXI_awlen),
        .load_burst (S_AXI_awburst),
        .advance    (w_hs),
        .addr       (w_addr),
        .last       (w_last),
        .err        (w_gen_err)
    );

    // A wlast mismatch only poisons the response; beats already written stand.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            w_state   <= W_IDLE;
            wlast_err <= 1'b0;
        end else begin
            w_state <= w_next;
            if (aw_hs)
                wlast_err <= 1'b0;
            else if (w_hs && (S_AXI_wlast != w_last))
                wlast_err <= 1'b1;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_last) w_next = W_RESP;
            W_RESP:  if (S_AXI_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Read channel
    assign S_AXI_arready = (r_state == R_IDLE) && s_axi_aresetn;
    assign S_AXI_rvalid  = (r_state == R_VALID);
    assign S_AXI_rdata   = rdata_q;
    assign S_AXI_rlast   = S_AXI_rvalid && r_last;
    assign S_AXI_rresp   = (S_AXI_rvalid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign ar_hs   = S_AXI_arvalid && S_AXI_arready;
    assign r_adv   = S_AXI_rvalid && S_AXI_rready && !r_last;
    assign capture = (r_state == R_WAIT) && (lat_cnt == LAT_LAST);

    assign mem_re    = (r_state == R_ISSUE) && !r_err;
    assign mem_raddr = r_addr;

    axi_burst_addr_gen #(.MW(MW)) u_rgen (
        .clk        (s_axi_aclk),
        .rst_n      (s_axi_aresetn),
        .load       (ar_hs),
        .load_addr  (S_AXI_araddr[ADDR_WIDTH-1:OFF]),
        .load_len   (S_AXI_arlen),
        .load_burst (S_AXI_arburst),
        .advance    (r_adv),
        .addr       (r_addr),
        .last       (r_last),
        .err        (r_err)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            r_state <= R_IDLE;
            lat_cnt <= 1'b0;
            rdata_q <= '0;
        end else begin
            r_state <= r_next;
            lat_cnt <= (r_state == R_WAIT) ? !lat_cnt : 1'b0;
            if (capture)
                rdata_q <= r_err ? '0 : mem_rdata;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_ISSUE;
            R_ISSUE: r_next = R_WAIT;
            R_WAIT:  if (capture) r_next = R_VALID;
            R_VALID: if (S_AXI_rready) r_next = r_last ? R_IDLE : R_ISSUE;
            default: r_next = R_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_burst_mem_bridge.sv
// Directed bench for axi_burst_mem_bridge with a two-cycle
// latency word memory model behind the bridge.
module tb_axi_burst_mem_bridge;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [11:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [1:0]  awburst, arburst;
    logic        awvalid, awready, wvalid, wready, wlast;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready;
    logic [31:0] rdata;
    logic        rlast, rvalid, rready;
    logic        mem_we, mem_re;
    logic [9:0]  mem_waddr, mem_raddr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic [31:0] mem [0:1023];
    logic [31:0] p1, p2;
    logic        init_done = 1'b0;
    int          cyc = 0;
    int          we_count = 0;
    int          re_count = 0;
    int          we_addr[$];
    int          we_cyc[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    axi_burst_mem_bridge #(
        .DATA_WIDTH(32), .ADDR_WIDTH(12), .READ_LATENCY(2)
    ) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
        .S_AXI_awaddr(awaddr), .S_AXI_awlen(awlen),
        .S_AXI_awburst(awburst), .S_AXI_awvalid(awvalid),
        .S_AXI_awready(awready), .S_AXI_wdata(wdata),
        .S_AXI_wstrb(wstrb), .S_AXI_wlast(wlast),
        .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
        .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid),
        .S_AXI_bready(bready), .S_AXI_araddr(araddr),
        .S_AXI_arlen(arlen), .S_AXI_arburst(arburst),
        .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
        .S_AXI_rdata(rdata), .S_AXI_rresp(rresp),
        .S_AXI_rlast(rlast), .S_AXI_rvalid(rvalid),
        .S_AXI_rready(rready), .mem_we(mem_we),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_re(mem_re),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    assign mem_rdata = p2;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!init_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i);
            mem[0] <= 32'h0000C0DE;
            init_done <= 1'b1;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (mem_we) begin
            we_count = we_count + 1;
            we_addr.push_back(int'(mem_waddr));
            we_cyc.push_back(cyc);
        end
        if (mem_re) begin
            re_count = re_count + 1;
            p1 <= mem[mem_raddr];
        end
        p2 <= p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=waiting expected=handshake", tag);
    endtask

    task automatic do_aw(input logic [11:0] a, input logic [7:0] l, input logic [1:0] b);
        int n = 0;
        @(negedge clk);
        awaddr = a; awlen = l; awburst = b; awvalid = 1'b1;
        while (!awready && n < TMO) begin @(negedge clk); n++; end
        if (n == TMO) timeout("aw");
        @(posedge clk); #1 awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic last);
        int n = 0;
        @(negedge clk);
        wdata = d; wstrb = 4'hF; wlast = last; wvalid = 1'b1;
        while (!wready && n < TMO) begin @(negedge clk); n++; end
        if (n == TMO) timeout("w");
        @(posedge clk); #1 wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_b(output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        bready = 1'b1;
        while (!bvalid && n < TMO) begin @(negedge clk); n++; end
        if (n == TMO) timeout("b");
        resp = bresp;
        @(posedge clk); #1 bready = 1'b0;
    endtask

    task automatic do_ar(input logic [11:0] a, input logic [7:0] l, input logic [1:0] b);
        int n = 0;
        @(negedge clk);
        araddr = a; arlen = l; arburst = b; arvalid = 1'b1;
        while (!arready && n < TMO) begin @(negedge clk); n++; end
        if (n == TMO) timeout("ar");
        @(posedge clk); #1 arvalid = 1'b0;
    endtask

    task automatic wait_rvalid();
        int n = 0;
        @(negedge clk);
        while (!rvalid && n < TMO) begin @(negedge clk); n++; end
        if (n == TMO) timeout("r");
    endtask

    task automatic do_r(output logic [31:0] d, output logic [1:0] resp, output logic last);
        wait_rvalid();
        d = rdata; resp = rresp; last = rlast;
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
    endtask

    logic [31:0] rd;
    logic [1:0]  rr, br;
    logic        rl;
    logic [31:0] exp_wrap [4];
    int          snap_we, snap_re, base;
    logic        stable;
    logic [31:0] held;

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; araddr = '0; arlen = '0; arburst = '0;
        arvalid = 1'b0; rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        aresetn = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);

        // WRAP read of word 6 within block 4..7
        exp_wrap[0] = 32'd6; exp_wrap[1] = 32'd7;
        exp_wrap[2] = 32'd4; exp_wrap[3] = 32'd5;
        snap_re = re_count;
        do_ar(12'h018, 8'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            do_r(rd, rr, rl);
            chk($sformatf("wrap_rdata%0d", i), rd, exp_wrap[i]);
            chk($sformatf("wrap_rlast%0d", i), rl, (i == 3));
            chk($sformatf("wrap_rresp%0d", i), rr, 2'b00);
        end
        chk("wrap_re_count", re_count - snap_re, 4);

        // INCR write of four beats from word 4
        base = we_addr.size();
        do_aw(12'h010, 8'd3, 2'b01);
        for (int i = 0; i < 4; i++) do_w(32'hA0 + 32'(i), i == 3);
        do_b(br);
        chk("incr_bresp", br, 2'b00);
        chk("incr_nwrites", we_addr.size() - base, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("incr_waddr%0d", i), we_addr[base + i], 4 + i);
        chk("incr_consecutive", we_cyc[base + 3] - we_cyc[base], 3);
        chk("incr_mem5", mem[5], 32'hA1);

        // FIXED write: three beats all on word 8
        base = we_addr.size();
        do_aw(12'h020, 8'd2, 2'b00);
        for (int i = 0; i < 3; i++) do_w(32'hB0 + 32'(i), i == 2);
        do_b(br);
        chk("fixed_bresp", br, 2'b00);
        chk("fixed_nwrites", we_addr.size() - base, 3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("fixed_waddr%0d", i), we_addr[base + i], 8);
        chk("fixed_mem8", mem[8], 32'hB2);

        // Reserved burst write
        snap_we = we_count;
        do_aw(12'h030, 8'd1, 2'b11);
        do_w(32'hDEAD0000, 1'b0);
        do_w(32'hDEAD0001, 1'b1);
        do_b(br);
        chk("rsvd_bresp", br, 2'b10);
        chk("rsvd_no_we", we_count - snap_we, 0);

        // WRAP with illegal length
        do_aw(12'h030, 8'd2, 2'b10);
        for (int i = 0; i < 3; i++) do_w(32'hBAD0 + 32'(i), i == 2);
        do_b(br);
        chk("badwrap_bresp", br, 2'b10);
        chk("badwrap_no_we", we_count - snap_we, 0);
        chk("badwrap_mem12", mem[12], 32'd12);

        // wlast asserted too early: writes happen, response errors
        snap_we = we_count;
        do_aw(12'h040, 8'd1, 2'b01);
        do_w(32'h11, 1'b1);
        do_w(32'h22, 1'b0);
        do_b(br);
        chk("wlast_bresp", br, 2'b10);
        chk("wlast_writes", we_count - snap_we, 2);

        // Reserved burst read
        snap_re = re_count;
        do_ar(12'h050, 8'd0, 2'b11);
        do_r(rd, rr, rl);
        chk("rsvd_rresp", rr, 2'b10);
        chk("rsvd_rdata", rd, 0);
        chk("rsvd_rlast", rl, 1);
        chk("rsvd_no_re", re_count - snap_re, 0);

        // INCR read across the top word with a stalled second beat
        snap_re = re_count;
        do_ar(12'hFFC, 8'd2, 2'b01);
        do_r(rd, rr, rl);
        chk("top_rdata0", rd, 32'h3FF);
        wait_rvalid();
        held = rdata;
        snap_re = re_count;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            stable = stable & rvalid & (rdata === held) & !rlast;
        end
        chk("stall_stable", stable, 1);
        chk("stall_no_re", re_count - snap_re, 0);
        chk("top_wrap_rdata1", held, 32'h0000C0DE);
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        do_r(rd, rr, rl);
        chk("top_rdata2", rd, 32'd1);
        chk("top_rlast2", rl, 1);

        // Reset during beat 2 of an 8-beat write
        do_aw(12'h100, 8'd7, 2'b01);
        do_w(32'h70, 1'b0);
        @(negedge clk);
        wdata = 32'h71; wstrb = 4'hF; wvalid = 1'b1; aresetn = 1'b0;
        @(posedge clk); #1;
        snap_we = we_count;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("midrst_awready_low", awready, 0);
        chk("midrst_we_in_reset", mem_we, 0);
        aresetn = 1'b1; wvalid = 1'b0;
        #1;
        chk("midrst_awready", awready, 1);
        chk("midrst_bvalid", bvalid, 0);
        repeat (3) @(negedge clk);
        chk("midrst_bvalid_later", bvalid, 0);
        chk("midrst_no_we", we_count - snap_we, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_burst_mem_bridge.md
Name: axi_burst_mem_bridge

Overview:
- Parametrised AXI4 burst slave that converts host bursts into a simple single-port-per-direction word memory interface (framebuffer/palette/command RAM).
- Generalises the fixed 32-bit/12-bit host port: configurable data/address width and memory read latency, with full FIXED/INCR/WRAP burst support and error responses.
- Sits between the host interconnect and the GPU's on-chip memories, in the host clock domain.

Parameters:
DATA_WIDTH, 32, bus and memory word width; power of two, 32..256.
ADDR_WIDTH, 12, byte address width; memory word address width MW = ADDR_WIDTH - log2(DATA_WIDTH/8).
READ_LATENCY, 1, memory read latency in cycles, from mem_re to mem_rdata valid; 1 or 2.

Ports:
s_axi_aclk  in  1  sole clock.
s_axi_aresetn  in  1  synchronous active-low reset.
S_AXI_awaddr  in  ADDR_WIDTH  write burst start byte address.
S_AXI_awlen  in  8  beats minus 1.
S_AXI_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
S_AXI_awvalid  in  1  / S_AXI_awready  out  1  AW handshake.
S_AXI_wdata  in  DATA_WIDTH  write beat data.
S_AXI_wstrb  in  DATA_WIDTH/8  byte enables.
S_AXI_wlast  in  1  last beat marker, checked only.
S_AXI_wvalid  in  1  / S_AXI_wready  out  1  W handshake.
S_AXI_bresp  out  2  00 OKAY, 10 SLVERR.
S_AXI_bvalid  out  1  / S_AXI_bready  in  1  B handshake.
S_AXI_araddr  in  ADDR_WIDTH  read burst start byte address.
S_AXI_arlen  in  8  beats minus 1.
S_AXI_arburst  in  2  as awburst.
S_AXI_arvalid  in  1  / S_AXI_arready  out  1  AR handshake.
S_AXI_rdata  out  DATA_WIDTH  read beat data.
S_AXI_rresp  out  2  per-beat response.
S_AXI_rlast  out  1  final beat.
S_AXI_rvalid  out  1  / S_AXI_rready  in  1  R handshake.
mem_we  out  1  memory write strobe, one per accepted W beat.
mem_waddr  out  MW  word write address.
mem_wdata  out  DATA_WIDTH  write data (= wdata).
mem_wstrb  out  DATA_WIDTH/8  byte enables (= wstrb).
mem_re  out  1  memory read strobe.
mem_raddr  out  MW  word read address.
mem_rdata  in  DATA_WIDTH  read data, READ_LATENCY after mem_re.

Behaviour:
- Reset (aresetn low at clock edge): both FSMs to IDLE, counters 0, awready/wready/bvalid/arready/rvalid/rlast/mem_we/mem_re = 0, bresp/rresp = 00. Reset mid-burst abandons the burst: no further mem_we/mem_re, no B/R for it.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. awready=1 only in W_IDLE. On AW handshake, latch addr word index, len, burst, err; err = (burst==11) or (burst==WRAP and len not in {1,3,7,15}).
- W_DATA: wready=1; mem_we = wvalid & !err, combinational, same cycle as beat; mem_waddr = current word address. Beat counter increments per beat; beat with count==len -> W_RESP. wlast disagreeing with count sets err (response only; writes already issued stand).
- W_RESP: bvalid=1, bresp = err ? 10 : 00, held until bready; then W_IDLE (awready back next cycle).
- Address update per beat: FIXED hold; INCR +1 modulo 2^MW (wraps at top of space); WRAP: low log2(len+1) bits increment modulo len+1, upper bits held.
- Read FSM R_IDLE -> R_ISSUE -> R_WAIT -> R_VALID. arready=1 only in R_IDLE; latch as for write. R_ISSUE: mem_re=1 one cycle (suppressed if err). R_WAIT: READ_LATENCY-1 cycles, then capture mem_rdata into output register (0 if err). R_VALID: rvalid=1, rresp per err, rlast = (count==len); on rready: last -> R_IDLE, else advance address -> R_ISSUE. Beat throughput 1 per READ_LATENCY+2 cycles.
- Read and write channels independent; simultaneous AW and AR both accepted same cycle; same-address ordering between them not guaranteed.
- rdata/rresp/rlast stable while rvalid & !rready.

Decomposition:
- Package gpu_axi_pkg: burst encodings (FIXED/INCR/WRAP), response codes (OKAY/SLVERR), FSM state enums, next-address function (addr, len, burst).
- One sub-module natural: axi_burst_addr_gen (combinational/registered next-address + beat counter), instanced once per channel.

Test Plan:
- INCR write awaddr=0x010, awlen=3, wdata 0xA0..0xA3 -> mem_we on 4 consecutive beat cycles, mem_waddr 4,5,6,7; bresp=00 after last beat.
- WRAP read araddr=0x018, arlen=3, mem pattern word=addr -> rdata 6,7,4,5, rlast on 4th beat only, rresp=00.
- FIXED write awlen=2 to 0x020 -> three mem_we all at mem_waddr 8, final value = 3rd beat.
- awburst=11 or WRAP awlen=2 -> all W beats accepted, no mem_we, bresp=10; arburst=11 -> rresp=10, rdata 0, no mem_re.
- rready held low 5 cycles mid-burst, READ_LATENCY=2 -> rvalid held, rdata stable, no extra mem_re; INCR at top word wraps to word 0.
- aresetn low during beat 2 of 8-beat write -> no mem_we after reset edge, bvalid 0, awready 1 in first cycle after release.
